// File: rtl/seven_segment_capture_pkg.sv
// rtl/seven_segment_capture_pkg.sv - segment pattern table and FSM state type for the 7-segment capture
package seven_segment_capture_pkg;

  // Segment patterns, bit6..bit0 = A..G, active-high; same table as the display-driver side
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/seven_segment_capture_if.sv
// rtl/seven_segment_capture_if.sv - display bus in, recovered value out
interface seven_segment_capture_if #(
  parameter int DW   = 7,
  parameter int ERRW = 8
);
  logic [DW-1:0]   seg_in;
  logic            sel_in;
  logic [7:0]      value;
  logic            value_valid;
  logic            digit_err;
  logic [ERRW-1:0] err_count;

  modport master (
    output seg_in, sel_in,
    input  value, value_valid, digit_err, err_count
  );

  modport slave (
    input  seg_in, sel_in,
    output value, value_valid, digit_err, err_count
  );
endinterface

// File: rtl/seven_segment_capture_seg_pattern_to_hex.sv
// rtl/seven_segment_capture_seg_pattern_to_hex.sv - combinational segment pattern to hex nibble decoder
module seg_pattern_to_hex
  import seven_segment_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  // Table lookup; anything outside the sixteen glyphs is not hex
  always_comb begin
    nibble   = 4'h0;
    is_hex   = 1'b1;
    is_blank = (seg == SEG_BLANK);
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - recovers a two-digit hex value from a multiplexed 7-segment bus; SEG_ERR_COUNT_EN adds a saturating error counter
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int DW     = 7,
  parameter int SETTLE = 16,
  parameter int ERRW   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  seven_segment_capture_if.slave bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);

  logic [DW-1:0] seg_meta_q, seg_meta_d, seg_s_q, seg_s_d, seg_prev_q, seg_prev_d;
  logic          sel_meta_q, sel_meta_d, sel_s_q, sel_s_d, sel_prev_q, sel_prev_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          hi_ok_q, hi_ok_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic [7:0]    value_q, value_d;
  logic          value_valid_q, value_valid_d;
  logic          digit_err_q, digit_err_d;
  logic          sel_edge, seg_change;
  logic [3:0]    nibble;
  logic          is_hex, is_blank;

  seg_pattern_to_hex u_decode (
    .seg      (seg_s_q),
    .nibble   (nibble),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  // Two-flop synchronizers plus one history stage for edge/change detection
  always_comb begin
    seg_meta_d = bus.seg_in;
    seg_s_d    = seg_meta_q;
    seg_prev_d = seg_s_q;
    sel_meta_d = bus.sel_in;
    sel_s_d    = sel_meta_q;
    sel_prev_d = sel_s_q;
  end

  // Settle/sample FSM and pair assembly; a select edge mid-settle breaks the pair
  always_comb begin
    sel_edge      = (sel_s_q != sel_prev_q);
    seg_change    = (seg_s_q != seg_prev_q);
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    hi_ok_d       = hi_ok_q;
    hi_nib_d      = hi_nib_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    digit_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          phase_d = sel_s_q;
        end
      end
      ST_SETTLE: begin
        if (sel_edge) begin
          cnt_d   = '0;
          phase_d = sel_s_q;
          hi_ok_d = 1'b0;
        end else if (seg_change) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_IDLE;
        if (is_blank) begin
          hi_ok_d = 1'b0;
        end else if (!is_hex) begin
          digit_err_d = 1'b1;
          hi_ok_d     = 1'b0;
        end else if (phase_q) begin
          hi_nib_d = nibble;
          hi_ok_d  = 1'b1;
        end else if (hi_ok_q) begin
          value_d       = {hi_nib_q, nibble};
          value_valid_d = 1'b1;
          hi_ok_d       = 1'b0;
        end
        // Select edge arriving while sampling starts the next digit directly
        if (sel_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          phase_d = sel_s_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_meta_q    <= '0;
      seg_s_q       <= '0;
      seg_prev_q    <= '0;
      sel_meta_q    <= 1'b0;
      sel_s_q       <= 1'b0;
      sel_prev_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      phase_q       <= 1'b0;
      hi_ok_q       <= 1'b0;
      hi_nib_q      <= 4'h0;
      value_q       <= 8'h00;
      value_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
    end else begin
      seg_meta_q    <= seg_meta_d;
      seg_s_q       <= seg_s_d;
      seg_prev_q    <= seg_prev_d;
      sel_meta_q    <= sel_meta_d;
      sel_s_q       <= sel_s_d;
      sel_prev_q    <= sel_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      hi_ok_q       <= hi_ok_d;
      hi_nib_q      <= hi_nib_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      digit_err_q   <= digit_err_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.digit_err   = digit_err_q;

`ifdef SEG_ERR_COUNT_EN
  logic [ERRW-1:0] err_count_q, err_count_d;

  // Saturating count, updated in step with the digit_err register
  always_comb begin
    err_count_d = err_count_q;
    if (digit_err_d && (err_count_q != {ERRW{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - scoreboard bench for seven_segment_capture
module tb_seven_segment_capture;

`ifdef SEG_ERR_COUNT_EN
  localparam int ERRCNT_AFTER_T4 = 1;
`else
  localparam int ERRCNT_AFTER_T4 = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_segment_capture_if #(.DW(7), .ERRW(8)) bus ();

  seven_segment_capture #(.DW(7), .SETTLE(16), .ERRW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int phase_start = 0;
  int last_lat = -1;
  int n_valid = 0;
  int n_err = 0;
  int v0, e0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every value_valid pulse pops and compares one scoreboard entry
  always @(negedge clk) begin
    if (!reset && bus.value_valid === 1'b1) begin
      n_valid++;
      last_lat = cyc - phase_start;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid actual=%0h required=none", bus.value);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.value !== sb_exp) begin
          bad++;
          $display("FAIL sb_value actual=%0h required=%0h", bus.value, sb_exp);
        end
      end
    end
    if (!reset && bus.digit_err === 1'b1) n_err++;
  end

  task automatic drive(input logic s, input logic [6:0] g, input int n);
    @(posedge clk);
    #1;
    bus.sel_in  = s;
    bus.seg_in  = g;
    phase_start = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    reset      = 1'b1;
    bus.sel_in = 1'b0;
    bus.seg_in = 7'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_value", bus.value, 8'h00);
    check("reset_valid", bus.value_valid, 1'b0);
    check("reset_err", bus.digit_err, 1'b0);
    check("reset_errcnt", bus.err_count, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: basic pair 2/E
    mark();
    exp_q.push_back(8'h2E);
    drive(1'b1, 7'h6D, 40);
    drive(1'b0, 7'h4F, 40);
    @(negedge clk);
    check("t1_nvalid", n_valid - v0, 1);
    check("t1_value", bus.value, 8'h2E);
    check("t1_nerr", n_err - e0, 0);

    // 2: hi bounces every 8 cycles before settling on 1, lo 0
    mark();
    exp_q.push_back(8'h10);
    drive(1'b1, 7'h30, 8);
    drive(1'b1, 7'h33, 8);
    drive(1'b1, 7'h30, 8);
    drive(1'b1, 7'h33, 8);
    drive(1'b1, 7'h30, 40);
    drive(1'b0, 7'h7E, 40);
    @(negedge clk);
    check("t2_nvalid", n_valid - v0, 1);
    check("t2_value", bus.value, 8'h10);
    check("t2_lat_min", (last_lat >= 18), 1'b1);
    check("t2_lat_max", (last_lat <= 22), 1'b1);

    // 3: blank hi breaks the pair silently
    mark();
    drive(1'b1, 7'h00, 40);
    drive(1'b0, 7'h79, 40);
    @(negedge clk);
    check("t3_nvalid", n_valid - v0, 0);
    check("t3_nerr", n_err - e0, 0);
    check("t3_value_hold", bus.value, 8'h10);

    // 4: illegal hi pattern
    mark();
    drive(1'b1, 7'h01, 40);
    drive(1'b0, 7'h7E, 40);
    @(negedge clk);
    check("t4_nerr", n_err - e0, 1);
    check("t4_nvalid", n_valid - v0, 0);
    check("t4_errcnt", bus.err_count, ERRCNT_AFTER_T4);

    // 5: hi interrupted by a select edge, then a clean pair F/b
    mark();
    drive(1'b1, 7'h5B, 5);
    drive(1'b0, 7'h5F, 40);
    @(negedge clk);
    check("t5_broken_nvalid", n_valid - v0, 0);
    mark();
    exp_q.push_back(8'hFB);
    drive(1'b1, 7'h47, 40);
    drive(1'b0, 7'h1F, 40);
    @(negedge clk);
    check("t5_nvalid", n_valid - v0, 1);
    check("t5_value", bus.value, 8'hFB);

    // 6: reset during lo settle after a good hi
    drive(1'b1, 7'h7F, 40);
    drive(1'b0, 7'h77, 8);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_value", bus.value, 8'h00);
    check("t6_rst_valid", bus.value_valid, 1'b0);
    check("t6_rst_err", bus.digit_err, 1'b0);
    check("t6_rst_errcnt", bus.err_count, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    mark();
    drive(1'b0, 7'h7E, 40);
    @(negedge clk);
    check("t6_lo_only_nvalid", n_valid - v0, 0);
    check("t6_lo_only_value", bus.value, 8'h00);
    mark();
    exp_q.push_back(8'h8A);
    drive(1'b1, 7'h7F, 40);
    drive(1'b0, 7'h77, 40);
    @(negedge clk);
    check("t6_nvalid", n_valid - v0, 1);
    check("t6_value", bus.value, 8'h8A);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
